// File: rtl/gba_lcd_capture.sv
// gba_lcd_capture: synchronise GBA LCD timing/RGB, track frame/line structure and write active pixels to a (ping-pong) framebuffer
module gba_lcd_capture #(
  parameter int H_ACTIVE    = 240,
  parameter int V_ACTIVE    = 160,
  parameter int V_SKIP      = 5,
  parameter int CW          = 5,
  parameter int ADDR_W      = 17,
  parameter int DOUBLE_BUF  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_DCLK,
  input  logic              i_LP,
  input  logic              i_SPL,
  input  logic              i_SPS,
  input  logic [CW-1:0]     i_R,
  input  logic [CW-1:0]     i_G,
  input  logic [CW-1:0]     i_B,
  input  logic              i_err_clr,
  output logic              o_wre,
  output logic [ADDR_W-1:0] o_wraddr,
  output logic [3*CW-1:0]   o_data,
  output logic              o_frame_done,
  output logic              o_buf,
  output logic [7:0]        o_frame_count,
  output logic              o_err_hlong,
  output logic              o_err_vshort,
  output logic [7:0]        o_LED
);
  localparam int IW = 3*CW+4;
  localparam int HW = $clog2(H_ACTIVE+1);
  localparam int VW = $clog2(V_ACTIVE+1);
  localparam int SW = $clog2(V_SKIP+1);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(H_ACTIVE*V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_SZ  = ADDR_W'(H_ACTIVE);
  typedef enum logic [2:0] {IDLE, VSKIP, WAIT_LINE, ACTIVE, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] sync_q [SYNC_STAGES];
  logic [IW-1:0] s;
  logic [3:0] ctl_h;
  logic pix, lp_fall, spl_rise, sps_fall, in_frame, abort, wr, hlong;
  logic [HW-1:0] h;
  logic [VW-1:0] line;
  logic [SW-1:0] lp_cnt;
  logic [ADDR_W-1:0] line_base;
  logic region;
  assign s        = sync_q[SYNC_STAGES-1];
  assign pix      = ctl_h[3] & ~s[IW-1];
  assign lp_fall  = ctl_h[2] & ~s[IW-2];
  assign spl_rise = ~ctl_h[1] & s[IW-3];
  // frame start is the arrival of SPS low, so a long SPS pulse is not seen as a second frame start
  assign sps_fall = ctl_h[0] & ~s[IW-4];
  assign in_frame = state == VSKIP || state == WAIT_LINE || state == ACTIVE;
  assign abort    = sps_fall & in_frame;
  assign wr       = state == ACTIVE && !abort && pix && h < HW'(H_ACTIVE);
  assign hlong    = state == ACTIVE && !abort && pix && h >= HW'(H_ACTIVE);
  assign o_LED    = {o_err_vshort, o_err_hlong, o_buf, o_frame_count[4:0]};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = sps_fall ? VSKIP : IDLE;
      VSKIP:     state_nx = lp_cnt == SW'(V_SKIP) ? WAIT_LINE : VSKIP;
      WAIT_LINE: state_nx = spl_rise ? ACTIVE : WAIT_LINE;
      ACTIVE:    state_nx = !lp_fall ? ACTIVE : line == VW'(V_ACTIVE-1) ? DONE : WAIT_LINE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (abort) state_nx = VSKIP;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ctl_h <= '0;
      h <= '0;
      line <= '0;
      lp_cnt <= '0;
      line_base <= '0;
      region <= 1'b0;
      o_wre <= 1'b0;
      o_wraddr <= '0;
      o_data <= '0;
      o_frame_done <= 1'b0;
      o_buf <= 1'b0;
      o_frame_count <= '0;
      o_err_hlong <= 1'b0;
      o_err_vshort <= 1'b0;
    end else begin
      state <= state_nx;
      sync_q[0] <= {i_DCLK, i_LP, i_SPL, i_SPS, i_R, i_G, i_B};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ctl_h <= s[IW-1 -: 4];
      o_wre <= wr;
      o_frame_done <= state == DONE;
      o_err_hlong <= hlong | (o_err_hlong & ~i_err_clr);
      o_err_vshort <= abort | (o_err_vshort & ~i_err_clr);
      if (state == IDLE) lp_cnt <= '0;
      if (state == VSKIP) begin
        lp_cnt <= lp_fall ? lp_cnt + 1'b1 : lp_cnt;
        line <= '0;
        line_base <= region ? FRAME_SZ : '0;
      end
      if (state == WAIT_LINE) h <= '0;
      if (wr) begin
        o_wraddr <= line_base + ADDR_W'(h);
        o_data <= s[3*CW-1:0];
        h <= h + 1'b1;
      end
      if (state == ACTIVE && spl_rise) h <= '0;
      // the pixel above used the old line_base, so a coincident LP fall advances afterwards
      if (state == ACTIVE && lp_fall && !abort) begin
        line <= line + 1'b1;
        line_base <= line_base + LINE_SZ;
      end
      if (abort) lp_cnt <= '0;
      if (state == DONE) begin
        o_buf <= region;
        o_frame_count <= o_frame_count + 1'b1;
        if (DOUBLE_BUF != 0) region <= ~region;
      end
    end
  end
endmodule

// File: tb/tb_gba_lcd_capture.sv
// tb_gba_lcd_capture: directed frames against a pixel-level scoreboard model of the capture path
module tb_gba_lcd_capture;
  localparam int H = 8, V = 6, VS = 2, CW = 5, AW = 8, SS = 2;
  logic clk = 0, rst_n = 1, dclk = 1, lp = 1, spl = 0, sps = 1, err_clr = 0;
  logic [CW-1:0] r = 0, g = 0, b = 0;
  logic wre, done, buf_o, hlong, vshort;
  logic [AW-1:0] wraddr;
  logic [3*CW-1:0] data;
  logic [7:0] cnt, led;

  gba_lcd_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .V_SKIP(VS), .CW(CW), .ADDR_W(AW),
                    .DOUBLE_BUF(1), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_DCLK(dclk), .i_LP(lp), .i_SPL(spl), .i_SPS(sps),
    .i_R(r), .i_G(g), .i_B(b), .i_err_clr(err_clr),
    .o_wre(wre), .o_wraddr(wraddr), .o_data(data), .o_frame_done(done), .o_buf(buf_o),
    .o_frame_count(cnt), .o_err_hlong(hlong), .o_err_vshort(vshort), .o_LED(led));

  always #5 clk = ~clk;

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, done_seen = 0;
  int m_region = 0, m_count = 0, m_buf = 0, m_hlong = 0, m_vshort = 0, m_done = 0, m_in_frame = 0;
  bit armed = 0;
  logic [14:0] seen [256];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (armed && rst_n) begin
    if (wre) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wraddr, data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wraddr, e.addr);
        chk("wr_data", data, e.data);
        chk("wr_latency", cyc, e.cyc);
      end
      seen[wraddr] = data;
    end
    if (done) done_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    if (m_in_frame != 0) m_vshort = 1;
    m_in_frame = 1;
    sps = 0; tick(4); sps = 1; tick(4);
    repeat (VS) begin lp = 0; tick(4); lp = 1; tick(4); end
  endtask

  task automatic line(input int v, input int n, input int bv, input bit coin, input bit lp_end);
    spl = 1; tick(4); spl = 0; tick(4);
    for (int p = 0; p < n; p++) begin
      r = CW'(p); g = CW'(v); b = CW'(bv); dclk = 0;
      if (coin && p == n-1) lp = 0;
      if (p < H)
        exp_q.push_back(wr_t'{m_region*H*V + v*H + p, ((p & 31) << 10) | ((v & 31) << 5) | (bv & 31), cyc + SS + 1});
      else
        m_hlong = 1;
      tick(2); dclk = 1; tick(2);
    end
    if (lp_end) begin
      lp = 0; tick(4); lp = 1; tick(4);
      if (v == V-1) begin
        m_buf = m_region; m_count = (m_count + 1) % 256; m_done++; m_region ^= 1; m_in_frame = 0;
      end
    end
  endtask

  task automatic frame(input int bv, input int nlines, input int long_ln, input bit coin);
    start_frame();
    for (int v = 0; v < nlines; v++) line(v, v == long_ln ? H+5 : H, bv, coin && v == 0, 1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, cnt, m_count);
    chk({tag, "_buf"}, buf_o, m_buf);
    chk({tag, "_hlong"}, hlong, m_hlong);
    chk({tag, "_vshort"}, vshort, m_vshort);
    chk({tag, "_done_pulses"}, done_seen, m_done);
    chk({tag, "_led"}, led, (m_vshort << 7) | (m_hlong << 6) | (m_buf << 5) | (m_count & 31));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wre"}, wre, 0);
    chk({tag, "_wraddr"}, wraddr, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_buf"}, buf_o, 0);
    chk({tag, "_count"}, cnt, 0);
    chk({tag, "_hlong"}, hlong, 0);
    chk({tag, "_vshort"}, vshort, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  initial begin
    tick(2); rst_n = 0; tick(3); #1;
    check_reset("reset");
    tick(1); rst_n = 1; armed = 1; tick(4);

    frame(31, V, -1, 0);
    check_state("f1");
    chk("f1_pix9", seen[9], 15'h043F);
    chk("f1_count_lit", cnt, 1);
    chk("f1_buf_lit", buf_o, 0);

    frame(31, V, -1, 0);
    check_state("f2");
    chk("f2_pix95", seen[95], 15'h1CBF);
    chk("f2_count_lit", cnt, 2);
    chk("f2_buf_lit", buf_o, 1);

    frame(21, V, 3, 0);
    check_state("f3");
    chk("f3_hlong_lit", hlong, 1);
    chk("f3_pix31", seen[31], 15'h1C75);
    chk("f3_buf_lit", buf_o, 0);
    err_clr = 1; tick(1); err_clr = 0; m_hlong = 0; tick(1);
    chk("errclr_hlong", hlong, 0);

    frame(9, 3, -1, 0);
    check_state("abort_partial");
    frame(9, V, -1, 0);
    check_state("f4");
    chk("f4_vshort_lit", vshort, 1);
    chk("f4_count_lit", cnt, 4);
    chk("f4_buf_lit", buf_o, 1);

    frame(10, V, -1, 1);
    check_state("f5");
    chk("f5_pix7", seen[7], 15'h1C0A);
    chk("f5_pix8", seen[8], 15'h002A);

    start_frame();
    for (int v = 0; v < 3; v++) line(v, H, 12, 0, 1);
    line(3, 4, 12, 0, 0);
    rst_n = 0; #1;
    check_reset("midreset");
    chk("midreset_pending", exp_q.size(), 0);
    exp_q.delete();
    m_region = 0; m_count = 0; m_buf = 0; m_hlong = 0; m_vshort = 0; m_in_frame = 0;
    tick(2); rst_n = 1; tick(4);

    frame(3, V, -1, 0);
    check_state("f6");
    chk("f6_count_lit", cnt, 1);
    chk("f6_buf_lit", buf_o, 0);
    chk("f6_pix0", seen[0], 15'h0003);

    tick(10);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
